// File: rtl/mult8_control.sv
`timescale 1ns/1ps
// Purpose : sequencing controller for the signed shift-add multiplier datapath.
// Latency : Done rises 17 cycles after the start edge (NBITS=8): 1 CLEAR + NBITS x (ADD, SHIFT).
// Flow    : no backpressure; Run is a level, HOLD waits for Run to drop before re-arming.
//
// Ports:
//   Clk          system clock, all state changes on the rising edge
//   Reset_n      synchronous active-low reset
//   Run          start request (level, pre-synchronized)
//   ClearA_LoadB clear X/A and load B request (level, honoured in IDLE only)
//   M            current multiplier LSB, B[0], from the datapath
//   Clr_Ld       datapath: clear X and A, load B
//   ClearXA      datapath: clear X and A, keep B
//   Add          datapath: XA <= {A[7],A} + {S[7],S}
//   Sub          datapath: XA <= {A[7],A} - {S[7],S}
//   Shift        datapath: arithmetic right shift of X:A:B
//   Done         product valid in A:B
//   Busy         multiply in progress
module mult8_control #(
  parameter int NBITS = 8
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_Ld,
  output logic ClearXA,
  output logic Add,
  output logic Sub,
  output logic Shift,
  output logic Done,
  output logic Busy
);

  // One extra bit so the counter can hold NBITS itself after the last shift.
  localparam int CW = $clog2(NBITS) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ADD,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_last_bit;

  assign w_last_bit = (r_cnt == LAST_BIT);

  // State and bit counter. Reset abandons any partial product; the datapath
  // registers are left as they are.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next state and strobes. Add/Sub additionally depend on M; Clr_Ld passes
  // the load switch through while idle; everything else is state-decoded.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    Clr_Ld       = 1'b0;
    ClearXA      = 1'b0;
    Add          = 1'b0;
    Sub          = 1'b0;
    Shift        = 1'b0;
    Done         = 1'b0;
    Busy         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (Run) begin
          // Start wins over a simultaneous load request.
          w_next_state = S_CLEAR;
        end else begin
          Clr_Ld = ClearA_LoadB;
        end
      end

      S_CLEAR: begin
        ClearXA      = 1'b1;
        Busy         = 1'b1;
        w_cnt_next   = '0;
        w_next_state = S_ADD;
      end

      S_ADD: begin
        Busy = 1'b1;
        // The sign bit of a two's-complement multiplier carries negative
        // weight, so the final partial product is subtracted.
        if (M) begin
          if (w_last_bit) begin
            Sub = 1'b1;
          end else begin
            Add = 1'b1;
          end
        end
        w_next_state = S_SHIFT;
      end

      S_SHIFT: begin
        Shift      = 1'b1;
        Busy       = 1'b1;
        w_cnt_next = r_cnt + CW'(1);
        if (w_last_bit) begin
          w_next_state = S_HOLD;
        end else begin
          w_next_state = S_ADD;
        end
      end

      S_HOLD: begin
        Done = 1'b1;
        // Requires Run to be released before another multiply can start.
        if (!Run) begin
          w_next_state = S_IDLE;
        end
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Datapath strobes must never overlap.
  a_strobe_onehot: assert property (@(posedge Clk) disable iff (!Reset_n)
    $onehot0({Clr_Ld, ClearXA, Add, Sub, Shift}));

endmodule

// File: tb/tb_mult8_control.sv
`timescale 1ns/1ps
// Bench for mult8_control: directed multiplies against a behavioural datapath,
// with expected per-cycle output vectors queued by the stimulus and consumed
// by a negedge monitor whenever the controller shows any activity.
module tb_mult8_control;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic Run = 1'b0;
  logic ClearA_LoadB = 1'b0;
  logic M;
  logic Clr_Ld, ClearXA, Add, Sub, Shift, Done, Busy;

  // Behavioural datapath: switches, X, A, B.
  logic [7:0] sw   = 8'h00;
  logic       dp_x = 1'b0;
  logic [7:0] dp_a = 8'h00;
  logic [7:0] dp_b = 8'h00;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;
  logic [6:0] exp_q[$];

  // Output vector order: {Clr_Ld, ClearXA, Add, Sub, Shift, Done, Busy}
  localparam logic [6:0] V_CLR = 7'b1000000;
  localparam logic [6:0] V_CXA = 7'b0100000;
  localparam logic [6:0] V_ADD = 7'b0010000;
  localparam logic [6:0] V_SUB = 7'b0001000;
  localparam logic [6:0] V_SHF = 7'b0000100;
  localparam logic [6:0] V_DN  = 7'b0000010;
  localparam logic [6:0] V_BSY = 7'b0000001;

  mult8_control #(.NBITS(8)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .M            (M),
    .Clr_Ld       (Clr_Ld),
    .ClearXA      (ClearXA),
    .Add          (Add),
    .Sub          (Sub),
    .Shift        (Shift),
    .Done         (Done),
    .Busy         (Busy)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (Clr_Ld) begin
      dp_x <= 1'b0;
      dp_a <= 8'h00;
      dp_b <= sw;
    end else if (ClearXA) begin
      dp_x <= 1'b0;
      dp_a <= 8'h00;
    end else if (Add) begin
      {dp_x, dp_a} <= {dp_a[7], dp_a} + {sw[7], sw};
    end else if (Sub) begin
      {dp_x, dp_a} <= {dp_a[7], dp_a} + (~{sw[7], sw} + 9'd1);
    end else if (Shift) begin
      dp_a <= {dp_x, dp_a[7:1]};
      dp_b <= {dp_a[0], dp_b[7:1]};
    end
  end

  assign M = dp_b[0];

  // Monitor: every cycle with any nonzero output pops one expected vector.
  always @(negedge Clk) begin
    logic [6:0] got;
    logic [6:0] want;
    if (mon_en) begin
      got = {Clr_Ld, ClearXA, Add, Sub, Shift, Done, Busy};
      if (got !== 7'b0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_output got=%b want=none t=%0t", got, $time);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_errors++;
            $display("FAIL output_vector got=%b want=%b t=%0t", got, want, $time);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
    end
  endtask

  // Queue CLEAR, the ADD/SHIFT pairs for multiplier b, and n_done HOLD cycles.
  task automatic push_mult(input logic [7:0] b, input int n_done);
    exp_q.push_back(V_CXA | V_BSY);
    for (int k = 0; k < 8; k++) begin
      if (b[k]) exp_q.push_back(V_BSY | ((k < 7) ? V_ADD : V_SUB));
      else      exp_q.push_back(V_BSY);
      exp_q.push_back(V_BSY | V_SHF);
    end
    repeat (n_done) exp_q.push_back(V_DN);
  endtask

  // Hold Run for r edges; HOLD is entered 18 edges after Run rises.
  task automatic run_mult(input logic [7:0] b, input int r);
    int n_done;
    n_done = (r >= 18) ? (r - 17) : 1;
    push_mult(b, n_done);
    Run = 1'b1;
    repeat (r) tick();
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    if (r < 20) repeat (20 - r) tick();
    repeat (2) tick();
  endtask

  task automatic load(input logic [7:0] v, input int n);
    sw = v;
    ClearA_LoadB = 1'b1;
    repeat (n) begin
      exp_q.push_back(V_CLR);
      tick();
    end
    ClearA_LoadB = 1'b0;
    tick();
  endtask

  initial begin
    // Reset held with Run high: controller stays idle and silent.
    Reset_n = 1'b0;
    Run = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    chk("rst_strobes", 16'({Clr_Ld, ClearXA, Add, Sub, Shift}), 16'h0);
    chk("rst_done", 16'(Done), 16'h0);
    chk("rst_busy", 16'(Busy), 16'h0);

    // Release with Run still high: CLEAR on the next cycle.
    Reset_n = 1'b1;
    run_mult(8'h00, 20);
    chk("prod_0x0", {dp_a, dp_b}, 16'h0000);

    // Load in IDLE for 3 cycles, then 3 x 7.
    load(8'h07, 3);
    chk("load_b", 16'(dp_b), 16'h0007);
    sw = 8'h03;
    run_mult(8'h07, 18);
    chk("prod_7x3", {dp_a, dp_b}, 16'h0015);

    // -1 x -1 with a short Run pulse.
    load(8'hFF, 1);
    run_mult(8'hFF, 5);
    chk("prod_m1xm1", {dp_a, dp_b}, 16'h0001);

    // Run and load together: start wins, B keeps 0x01; Run held 31 edges.
    sw = 8'h05;
    ClearA_LoadB = 1'b1;
    Run = 1'b1;
    #1;
    chk("start_wins_clr_ld", 16'(Clr_Ld), 16'h0);
    run_mult(8'h01, 31);
    chk("prod_5x1", {dp_a, dp_b}, 16'h0005);

    // Re-arm after release: 5 x 5.
    run_mult(8'h05, 20);
    chk("prod_5x5", {dp_a, dp_b}, 16'h0019);

    // Reset during the 5th ADD (B=0x5A: bits 0..4 = 0,1,0,1,1).
    load(8'h5A, 1);
    sw = 8'h11;
    exp_q.push_back(V_CXA | V_BSY);
    exp_q.push_back(V_BSY);          exp_q.push_back(V_BSY | V_SHF);
    exp_q.push_back(V_BSY | V_ADD);  exp_q.push_back(V_BSY | V_SHF);
    exp_q.push_back(V_BSY);          exp_q.push_back(V_BSY | V_SHF);
    exp_q.push_back(V_BSY | V_ADD);  exp_q.push_back(V_BSY | V_SHF);
    exp_q.push_back(V_BSY | V_ADD);
    Run = 1'b1;
    repeat (10) tick();
    Reset_n = 1'b0;
    Run = 1'b0;
    tick();
    chk("midrst_busy", 16'(Busy), 16'h0);
    chk("midrst_done", 16'(Done), 16'h0);
    chk("midrst_shift", 16'(Shift), 16'h0);
    chk("midrst_queue", 16'(exp_q.size()), 16'h0);
    repeat (2) tick();
    Reset_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_busy", 16'(Busy), 16'h0);

    // Idle with no requests: all outputs low.
    repeat (4) tick();
    chk("idle_outputs", 16'({Clr_Ld, ClearXA, Add, Sub, Shift, Done, Busy}), 16'h0);

    chk("queue_empty", 16'(exp_q.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
